// File: rtl/sram_stream_writer.sv
// Write-only controller for an asynchronous SRAM. It buffers incoming address/data words
// in a small FIFO and turns each word into a registered CE/WE write cycle.
module sram_stream_writer #(
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned WR_WAIT    = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic              busy,
   output logic [31:0]       wr_count,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic [DATA_W-1:0] SRAM_DATA_O,
   output logic              SRAM_DATA_OE,
   output logic              SRAM_CEn,
   output logic              SRAM_WEn,
   output logic              SRAM_OEn
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned ENT_W  = ADDR_W + DATA_W;
   localparam int unsigned WAIT_W = 4;

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

   state_e              state_q, state_d;
   logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                push, pop, empty, full;
   logic [ENT_W-1:0]    head;

   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                cen_q, cen_d, wen_q, wen_d, oe_q, oe_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [31:0]         wr_count_q, wr_count_d;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign push     = in_valid && !full;
   assign pop      = ((state_q == IDLE) || (state_q == HOLD)) && !empty;
   assign head     = mem_q[rd_ptr_q];

   // FIFO storage is not reset; only the pointers and count define its contents
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= {in_addr, in_data};
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // State register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!empty) state_d = SETUP;
         SETUP:   state_d = PULSE;
         PULSE:   if (wait_q == '0) state_d = HOLD;
         HOLD:    state_d = empty ? IDLE : SETUP;
         default: state_d = IDLE;
      endcase
   end

   // Strobes are derived from the next state so each registered output lines up with its state
   always_comb begin
      cen_d      = (state_d == IDLE);
      wen_d      = (state_d != PULSE);
      oe_d       = (state_d != IDLE);
      addr_d     = addr_q;
      data_d     = data_q;
      wait_d     = wait_q;
      wr_count_d = wr_count_q;
      if (pop) {addr_d, data_d} = head;
      if (state_q == SETUP)                      wait_d = WAIT_W'(WR_WAIT - 1);
      else if (state_q == PULSE && wait_q != '0) wait_d = wait_q - WAIT_W'(1);
      if (state_q == HOLD) wr_count_d = wr_count_q + 32'd1;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cen_q      <= 1'b1;
         wen_q      <= 1'b1;
         oe_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         wait_q     <= '0;
         wr_count_q <= '0;
      end else begin
         cen_q      <= cen_d;
         wen_q      <= wen_d;
         oe_q       <= oe_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wait_q     <= wait_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign in_ready     = !full;
   assign busy         = (state_q != IDLE) || !empty;
   assign wr_count     = wr_count_q;
   assign SRAM_ADDR    = addr_q;
   assign SRAM_DATA_O  = data_q;
   assign SRAM_DATA_OE = oe_q;
   assign SRAM_CEn     = cen_q;
   assign SRAM_WEn     = wen_q;
   assign SRAM_OEn     = 1'b1;

endmodule

// File: tb/tb_sram_stream_writer.sv
// Directed bench for sram_stream_writer: one instance at WR_WAIT=2 and one at WR_WAIT=5,
// observed on the falling clock edge.
module tb_sram_stream_writer;

   localparam int unsigned AW = 19;
   localparam int unsigned DW = 32;

   logic CLK = 1'b0;
   logic RSTn;
   always #5 CLK = ~CLK;

   logic          a_valid, a_ready, a_busy, a_oe, a_cen, a_wen, a_oen;
   logic [AW-1:0] a_addr, a_sram_addr;
   logic [DW-1:0] a_data, a_sram_data;
   logic [31:0]   a_cnt;
   logic          b_valid, b_ready, b_busy, b_oe, b_cen, b_wen, b_oen;
   logic [AW-1:0] b_addr, b_sram_addr;
   logic [DW-1:0] b_data, b_sram_data;
   logic [31:0]   b_cnt;

   sram_stream_writer #(.ADDR_W(AW), .DATA_W(DW), .WR_WAIT(2), .FIFO_DEPTH(4)) dut_a (
      .CLK(CLK), .RSTn(RSTn), .in_valid(a_valid), .in_ready(a_ready), .in_addr(a_addr),
      .in_data(a_data), .busy(a_busy), .wr_count(a_cnt), .SRAM_ADDR(a_sram_addr),
      .SRAM_DATA_O(a_sram_data), .SRAM_DATA_OE(a_oe), .SRAM_CEn(a_cen), .SRAM_WEn(a_wen),
      .SRAM_OEn(a_oen));

   sram_stream_writer #(.ADDR_W(AW), .DATA_W(DW), .WR_WAIT(5), .FIFO_DEPTH(4)) dut_b (
      .CLK(CLK), .RSTn(RSTn), .in_valid(b_valid), .in_ready(b_ready), .in_addr(b_addr),
      .in_data(b_data), .busy(b_busy), .wr_count(b_cnt), .SRAM_ADDR(b_sram_addr),
      .SRAM_DATA_O(b_sram_data), .SRAM_DATA_OE(b_oe), .SRAM_CEn(b_cen), .SRAM_WEn(b_wen),
      .SRAM_OEn(b_oen));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge CLK) cyc++;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            fall;
      int            cen_hi;
   } wr_t;

   wr_t obs_a[$];
   wr_t obs_b[$];

   // Write monitor for instance A: logs each WE fall, checks bus stability and pulse width
   int            a_run = 0;
   int            a_cen_hi = 0;
   logic          a_pw = 1'b1;
   logic [AW-1:0] a_pa = '0;
   logic [DW-1:0] a_pd = '0;
   always @(negedge CLK) begin
      if (!RSTn) begin
         a_pw  = 1'b1;
         a_run = 0;
      end else begin
         if (a_cen) a_cen_hi++;
         if (!a_wen) begin
            if (a_pw) obs_a.push_back('{addr: a_sram_addr, data: a_sram_data, fall: cyc, cen_hi: a_cen_hi});
            else begin
               check_eq("a_addr_hold", 64'(a_sram_addr), 64'(a_pa));
               check_eq("a_data_hold", 64'(a_sram_data), 64'(a_pd));
            end
            check_eq("a_cen_in_pulse", 64'(a_cen), 64'(0));
            a_run++;
         end else if (!a_pw) begin
            check_eq("a_we_width", 64'(a_run), 64'(2));
            a_run = 0;
         end
         a_pw = a_wen;
         a_pa = a_sram_addr;
         a_pd = a_sram_data;
      end
   end

   int   b_run = 0;
   logic b_pw = 1'b1;
   always @(negedge CLK) begin
      if (!RSTn) begin
         b_pw  = 1'b1;
         b_run = 0;
      end else begin
         if (!b_wen) begin
            if (b_pw) obs_b.push_back('{addr: b_sram_addr, data: b_sram_data, fall: cyc, cen_hi: 0});
            b_run++;
         end else if (!b_pw) begin
            check_eq("b_we_width", 64'(b_run), 64'(5));
            b_run = 0;
         end
         b_pw = b_wen;
      end
   end

   task automatic wait_idle_a(input int lim);
      int n = 0;
      @(negedge CLK);
      while (a_busy && n < lim) begin
         @(negedge CLK);
         n++;
      end
      check_eq("a_idle_timeout", 64'(a_busy), 64'(0));
   endtask

   task automatic wait_idle_b(input int lim);
      int n = 0;
      @(negedge CLK);
      while (b_busy && n < lim) begin
         @(negedge CLK);
         n++;
      end
      check_eq("b_idle_timeout", 64'(b_busy), 64'(0));
   endtask

   // Pushes n words into A on consecutive edges; A must not fill during this
   task automatic push_a(input logic [AW-1:0] base, input logic [DW-1:0] dbase, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         a_valid = 1'b1;
         a_addr  = base + AW'(i);
         a_data  = dbase + DW'(i);
         check_eq("a_ready_push", 64'(a_ready), 64'(1));
         @(posedge CLK);
      end
      @(negedge CLK);
      a_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] t1 [6];
      int         first_full;
      int         i;
      int         guard;
      int         n;
      logic       rdy;
      logic       saw_zero;
      logic       prevw;

      RSTn = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      repeat (3) @(negedge CLK);
      RSTn = 1'b1;
      @(negedge CLK);

      check_eq("rst_ready", 64'(a_ready), 64'(1));
      check_eq("rst_busy", 64'(a_busy), 64'(0));
      check_eq("rst_count", 64'(a_cnt), 64'(0));
      check_eq("rst_addr", 64'(a_sram_addr), 64'(0));
      check_eq("rst_data", 64'(a_sram_data), 64'(0));
      check_eq("rst_oe", 64'(a_oe), 64'(0));
      check_eq("rst_cen", 64'(a_cen), 64'(1));
      check_eq("rst_wen", 64'(a_wen), 64'(1));
      check_eq("rst_oen", 64'(a_oen), 64'(1));
      check_eq("rst_b_strobes", 64'({b_cen, b_wen, b_oen, b_oe}), 64'(4'b1110));

      // Single word: {CEn,WEn,OE,busy} per cycle after the accepting edge
      t1 = '{4'b1101, 4'b0111, 4'b0011, 4'b0011, 4'b0111, 4'b1100};
      a_valid = 1'b1; a_addr = AW'(5); a_data = 32'hDEAD_BEEF;
      @(posedge CLK);
      @(negedge CLK);
      a_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge CLK);
         check_eq($sformatf("t1_strobes_k%0d", k), 64'({a_cen, a_wen, a_oe, a_busy}), 64'(t1[k]));
         check_eq($sformatf("t1_count_k%0d", k), 64'(a_cnt), (k == 5) ? 64'(1) : 64'(0));
         check_eq($sformatf("t1_oen_k%0d", k), 64'(a_oen), 64'(1));
         if (k > 0) begin
            check_eq($sformatf("t1_addr_k%0d", k), 64'(a_sram_addr), 64'(5));
            check_eq($sformatf("t1_data_k%0d", k), 64'(a_sram_data), 64'(32'hDEAD_BEEF));
         end
      end

      // Eight back-to-back words with in_valid held high
      obs_a.delete();
      first_full = -1; i = 0; guard = 0;
      @(negedge CLK);
      a_valid = 1'b1;
      while (i < 8 && guard < 200) begin
         a_addr = AW'(i);
         a_data = 32'hA000_0000 + DW'(i);
         if (!a_ready && first_full < 0) first_full = i;
         rdy = a_ready;
         @(posedge CLK);
         if (rdy) i++;
         @(negedge CLK);
         guard++;
      end
      a_valid = 1'b0;
      check_eq("b2b_accepted", 64'(i), 64'(8));
      check_eq("b2b_first_full", 64'(first_full), 64'(5));
      wait_idle_a(200);
      check_eq("b2b_nwrites", 64'(obs_a.size()), 64'(8));
      check_eq("b2b_count", 64'(a_cnt), 64'(9));
      if (obs_a.size() == 8) begin
         for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("b2b_addr%0d", k), 64'(obs_a[k].addr), 64'(k));
            check_eq($sformatf("b2b_data%0d", k), 64'(obs_a[k].data), 64'(32'hA000_0000 + k));
            if (k > 0) check_eq($sformatf("b2b_period%0d", k), 64'(obs_a[k].fall - obs_a[k-1].fall), 64'(4));
         end
         check_eq("b2b_cen_gap", 64'(obs_a[7].cen_hi - obs_a[0].cen_hi), 64'(0));
      end

      // Push landing on the same edge as a pop while two words are buffered
      obs_a.delete();
      push_a(AW'(32'h100), 32'h5100_0000, 3);
      prevw = a_wen; n = 0;
      while (!(!a_cen && a_wen && a_oe && !prevw) && n < 50) begin
         prevw = a_wen;
         @(negedge CLK);
         n++;
      end
      check_eq("pp_hold_seen", 64'(n < 50), 64'(1));
      a_valid = 1'b1; a_addr = AW'(32'h103); a_data = 32'h5100_0003;
      check_eq("pp_ready", 64'(a_ready), 64'(1));
      @(posedge CLK);
      @(negedge CLK);
      a_valid = 1'b0;
      wait_idle_a(200);
      check_eq("pp_nwrites", 64'(obs_a.size()), 64'(4));
      check_eq("pp_count", 64'(a_cnt), 64'(13));
      if (obs_a.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("pp_addr%0d", k), 64'(obs_a[k].addr), 64'(32'h100 + k));
            check_eq($sformatf("pp_data%0d", k), 64'(obs_a[k].data), 64'(32'h5100_0000 + k));
         end
      end

      // WR_WAIT=5 instance: two words, seven-cycle period
      obs_b.delete();
      @(negedge CLK);
      b_valid = 1'b1; b_addr = AW'(32'h40); b_data = 32'hB000_0040;
      @(posedge CLK);
      @(negedge CLK);
      b_addr = AW'(32'h41); b_data = 32'hB000_0041;
      check_eq("ww_ready", 64'(b_ready), 64'(1));
      @(posedge CLK);
      @(negedge CLK);
      b_valid = 1'b0;
      wait_idle_b(300);
      check_eq("ww_nwrites", 64'(obs_b.size()), 64'(2));
      check_eq("ww_count", 64'(b_cnt), 64'(2));
      if (obs_b.size() == 2) begin
         check_eq("ww_period", 64'(obs_b[1].fall - obs_b[0].fall), 64'(7));
         check_eq("ww_addr0", 64'(obs_b[0].addr), 64'(32'h40));
         check_eq("ww_addr1", 64'(obs_b[1].addr), 64'(32'h41));
         check_eq("ww_data1", 64'(obs_b[1].data), 64'(32'hB000_0041));
      end

      // Reset asserted mid-pulse with words still buffered
      push_a(AW'(32'h200), 32'h7200_0000, 3);
      n = 0;
      while (a_wen && n < 50) begin
         @(negedge CLK);
         n++;
      end
      check_eq("rm_pulse_seen", 64'(a_wen), 64'(0));
      #2 RSTn = 1'b0;
      #1;
      check_eq("rm_wen", 64'(a_wen), 64'(1));
      check_eq("rm_cen", 64'(a_cen), 64'(1));
      check_eq("rm_oe", 64'(a_oe), 64'(0));
      check_eq("rm_count", 64'(a_cnt), 64'(0));
      check_eq("rm_busy", 64'(a_busy), 64'(0));
      check_eq("rm_ready", 64'(a_ready), 64'(1));
      @(negedge CLK);
      @(negedge CLK);
      RSTn = 1'b1;
      obs_a.delete();
      push_a(AW'(32'h2AA), 32'h1234_5678, 1);
      wait_idle_a(200);
      check_eq("rm_after_nwrites", 64'(obs_a.size()), 64'(1));
      check_eq("rm_after_count", 64'(a_cnt), 64'(1));
      if (obs_a.size() == 1) begin
         check_eq("rm_after_addr", 64'(obs_a[0].addr), 64'(32'h2AA));
         check_eq("rm_after_data", 64'(obs_a[0].data), 64'(32'h1234_5678));
      end

      // Completed-write counter wraps through zero
      @(negedge CLK);
      force dut_a.wr_count_q = 32'hFFFF_FFFE;
      @(negedge CLK);
      release dut_a.wr_count_q;
      @(negedge CLK);
      check_eq("wrap_preload", 64'(a_cnt), 64'(32'hFFFF_FFFE));
      obs_a.delete();
      push_a(AW'(32'h300), 32'h9300_0000, 3);
      saw_zero = 1'b0; n = 0;
      while (a_busy && n < 200) begin
         if (a_cnt == 32'd0) saw_zero = 1'b1;
         @(negedge CLK);
         n++;
      end
      check_eq("wrap_idle", 64'(a_busy), 64'(0));
      check_eq("wrap_saw_zero", 64'(saw_zero), 64'(1));
      check_eq("wrap_count", 64'(a_cnt), 64'(1));
      check_eq("wrap_nwrites", 64'(obs_a.size()), 64'(3));
      check_eq("wrap_strobes", 64'({a_cen, a_wen, a_oe}), 64'(3'b110));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
